// File: rtl/gesture_pkg.sv
// Shared constants and FSM state encoding for the gesture classifier datapath.
// The weight ROMs, the voxel binner and the scoring engine all take their sizes from here.
package gesture_pkg;

   localparam int unsigned NUM_CELLS   = 1280;  // 5 bins x 256 cells
   localparam int unsigned NUM_CLASSES = 4;
   localparam int unsigned WEIGHT_BITS = 8;
   localparam int unsigned COUNT_BITS  = 8;
   localparam int unsigned ACC_BITS    = 24;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StScan   = 3'd1,
      StDrain  = 3'd2,
      StArgmax = 3'd3,
      StDone   = 3'd4
   } state_e;

endpackage

// File: rtl/sat_mac.sv
// Single-class saturating multiply-accumulate.
// The product of the zero-extended count and the signed weight is added to the
// accumulator. Once the accumulator clamps it stays clamped until clear_i.
module sat_mac #(
   parameter int unsigned COUNT_BITS  = gesture_pkg::COUNT_BITS,
   parameter int unsigned WEIGHT_BITS = gesture_pkg::WEIGHT_BITS,
   parameter int unsigned ACC_BITS    = gesture_pkg::ACC_BITS
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear_i,
   input  logic                          en_i,
   input  logic        [COUNT_BITS-1:0]  count_i,
   input  logic signed [WEIGHT_BITS-1:0] weight_i,
   output logic signed [ACC_BITS-1:0]    acc_o
);

   // Count gets one extra bit so it is non-negative once treated as signed.
   localparam int unsigned PROD_BITS = COUNT_BITS + 1 + WEIGHT_BITS;
   // Sum is at least ACC_BITS+1 wide; it grows further when a single product is
   // wider than the accumulator, so no product is ever truncated before the clamp.
   localparam int unsigned SUM_BITS =
      ((ACC_BITS > PROD_BITS) ? ACC_BITS : PROD_BITS) + 1;

   localparam logic signed [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
   localparam logic signed [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};
   localparam logic signed [SUM_BITS-1:0] SUM_MAX =
      {{(SUM_BITS-ACC_BITS+1){1'b0}}, {(ACC_BITS-1){1'b1}}};
   localparam logic signed [SUM_BITS-1:0] SUM_MIN =
      {{(SUM_BITS-ACC_BITS+1){1'b1}}, {(ACC_BITS-1){1'b0}}};

   logic signed [ACC_BITS-1:0]  acc_q, acc_d;
   logic                        sat_q, sat_d;
   logic signed [PROD_BITS-1:0] cnt_ext, wgt_ext, prod;
   logic signed [SUM_BITS-1:0]  sum;

   // Product and widened sum.
   always_comb begin
      cnt_ext = PROD_BITS'({1'b0, count_i});
      wgt_ext = PROD_BITS'(weight_i);
      prod    = cnt_ext * wgt_ext;
      sum     = SUM_BITS'(prod) + SUM_BITS'(acc_q);
   end

   // Next accumulator value: clear, clamp-and-stick, or plain add.
   always_comb begin
      acc_d = acc_q;
      sat_d = sat_q;
      if (clear_i) begin
         acc_d = '0;
         sat_d = 1'b0;
      end else if (en_i && !sat_q) begin
         if (sum > SUM_MAX) begin
            acc_d = ACC_MAX;
            sat_d = 1'b1;
         end else if (sum < SUM_MIN) begin
            acc_d = ACC_MIN;
            sat_d = 1'b1;
         end else begin
            acc_d = sum[ACC_BITS-1:0];
         end
      end
   end

   // Accumulator state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         sat_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         sat_q <= sat_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/class_score_engine.sv
// Scans every voxel cell once, accumulating count x weight for each class,
// then picks the best-scoring class. Memory reads have one cycle of latency,
// so a single DRAIN cycle absorbs the last read before ARGMAX.
module class_score_engine #(
   parameter int unsigned NUM_CELLS   = gesture_pkg::NUM_CELLS,
   parameter int unsigned NUM_CLASSES = gesture_pkg::NUM_CLASSES,
   parameter int unsigned WEIGHT_BITS = gesture_pkg::WEIGHT_BITS,
   parameter int unsigned COUNT_BITS  = gesture_pkg::COUNT_BITS,
   parameter int unsigned ACC_BITS    = gesture_pkg::ACC_BITS
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   output logic                              busy,
   output logic [$clog2(NUM_CELLS)-1:0]      cell_addr,
   input  logic [COUNT_BITS-1:0]             voxel_count,
   input  logic [NUM_CLASSES*WEIGHT_BITS-1:0] weight_in,
   output logic [NUM_CLASSES*ACC_BITS-1:0]   scores,
   output logic [$clog2(NUM_CLASSES)-1:0]    best_class,
   output logic [ACC_BITS-1:0]               best_score,
   output logic                              done
);

   import gesture_pkg::*;

   localparam int unsigned ADDR_BITS = $clog2(NUM_CELLS);
   localparam int unsigned CLS_BITS  = $clog2(NUM_CLASSES);
   localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_CELLS - 1);

   state_e                     state_q, state_d;
   logic [ADDR_BITS-1:0]       addr_q, addr_d;
   logic                       rd_valid_q, rd_valid_d;
   logic [CLS_BITS-1:0]        best_class_q, best_class_d;
   logic signed [ACC_BITS-1:0] best_score_q, best_score_d;
   logic                       clear;

   logic signed [ACC_BITS-1:0] acc [NUM_CLASSES];
   logic [CLS_BITS-1:0]        arg_class;
   logic signed [ACC_BITS-1:0] arg_score;

   // Only a start seen in IDLE is accepted; it also wipes the accumulators.
   assign clear = (state_q == StIdle) && start;

   // Sequencer: address generation and state transitions.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rd_valid_d = (state_q == StScan);
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StScan;
               addr_d  = '0;
            end
         end
         StScan: begin
            if (addr_q == LAST_ADDR) begin
               state_d = StDrain;
            end else begin
               addr_d = addr_q + ADDR_BITS'(1);
            end
         end
         StDrain:  state_d = StArgmax;
         StArgmax: state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Argmax over final accumulators; strict compare keeps the lowest index on ties.
   always_comb begin
      arg_class = '0;
      arg_score = acc[0];
      for (int c = 1; c < NUM_CLASSES; c++) begin
         if (acc[c] > arg_score) begin
            arg_score = acc[c];
            arg_class = CLS_BITS'(c);
         end
      end
      best_class_d = (state_q == StArgmax) ? arg_class : best_class_q;
      best_score_d = (state_q == StArgmax) ? arg_score : best_score_q;
   end

   // Control and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         rd_valid_q   <= 1'b0;
         best_class_q <= '0;
         best_score_q <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         rd_valid_q   <= rd_valid_d;
         best_class_q <= best_class_d;
         best_score_q <= best_score_d;
      end
   end

   for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_mac
      sat_mac #(
         .COUNT_BITS  (COUNT_BITS),
         .WEIGHT_BITS (WEIGHT_BITS),
         .ACC_BITS    (ACC_BITS)
      ) u_mac (
         .clk      (clk),
         .rst      (rst),
         .clear_i  (clear),
         .en_i     (rd_valid_q),
         .count_i  (voxel_count),
         .weight_i (weight_in[c*WEIGHT_BITS +: WEIGHT_BITS]),
         .acc_o    (acc[c])
      );
      assign scores[c*ACC_BITS +: ACC_BITS] = acc[c];
   end

   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StDone);
   assign cell_addr  = addr_q;
   assign best_class = best_class_q;
   assign best_score = best_score_q;

endmodule
